// File: rtl/ads1115_sequencer_if.sv
// ads1115_sequencer_if
// Handshake between the ADS1115 transaction sequencer and the byte-level
// I2C engine that owns SDA/SCL.
//   instruction   sequencer -> engine  0=START 1=STOP 2=READ 3=WRITE
//   enable        sequencer -> engine  request level; low returns engine to idle
//   byte_to_send  sequencer -> engine  data byte for WRITE
//   byte_received engine -> sequencer  receive register, valid with complete
//   complete      engine -> sequencer  done flag; stays stale until enable is seen
// Modports: master = sequencer side, slave = engine side.
interface ads1115_sequencer_if;
  logic [1:0] instruction;
  logic       enable;
  logic [7:0] byte_to_send;
  logic [7:0] byte_received;
  logic       complete;

  modport master (
    output instruction, enable, byte_to_send,
    input  byte_received, complete
  );

  modport slave (
    input  instruction, enable, byte_to_send,
    output byte_received, complete
  );
endinterface

// File: rtl/ads1115_sequencer.sv
// ads1115_sequencer
// Runs one single-shot ADS1115 conversion per accepted start pulse by stepping
// the I2C engine through: config write, conversion wait, pointer write, and a
// two-byte read. The 16-bit result is presented with a one-cycle data_valid.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           one-cycle request, accepted only while busy=0
//   channel         single-ended input AIN0..3, latched on an accepted start
//   busy            high from the cycle after an accepted start through data_valid,
//                   and during the post-reset holdoff
//   data            last conversion result (first byte off the bus is the MSB)
//   data_valid      one-cycle strobe when data updates
//   i2c             engine handshake (ads1115_sequencer_if.master)
//
// Optional build macro: ADC_POLL_READY_EN
//   defined   : the fixed wait is replaced by polling the config register until
//               OS=1 (capped at 255 polls); WAIT_CYCLES is unused.
//   undefined : fixed WAIT_CYCLES delay between config and pointer write.
module ads1115_sequencer #(
  parameter logic [6:0]  I2C_ADDR    = 7'h48,
  parameter logic [2:0]  PGA         = 3'b001,
  parameter logic [2:0]  DR          = 3'b100,
  parameter int unsigned WAIT_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  channel,
  output logic        busy,
  output logic [15:0] data,
  output logic        data_valid,
  ads1115_sequencer_if.master i2c
);

  typedef enum logic [1:0] {
    INSTR_START = 2'd0,
    INSTR_STOP  = 2'd1,
    INSTR_READ  = 2'd2,
    INSTR_WRITE = 2'd3
  } instr_e;

  // Each step of the op list is one of these. The READ flavours only differ
  // in where the received byte goes.
  typedef enum logic [2:0] {
    OP_START,
    OP_STOP,
    OP_WRITE,
    OP_READ_HI,
    OP_READ_LO,
    OP_READ_OS,
    OP_READ_SKIP,
    OP_WAIT
  } op_kind_e;

  typedef struct packed {
    op_kind_e   kind;
    logic [7:0] wr_byte;
  } op_t;

  typedef enum logic [2:0] {
    S_HOLDOFF,
    S_IDLE,
    S_ISSUE,
    S_ARMED,
    S_WAIT_DONE,
    S_RELEASE,
    S_DELAY,
    S_DONE
  } state_e;

  localparam logic [7:0]  ADDR_WR      = {I2C_ADDR, 1'b0};
  localparam logic [7:0]  ADDR_RD      = {I2C_ADDR, 1'b1};
  localparam logic [7:0]  CFG_LO       = {DR, 5'b00011};
  localparam logic [23:0] HOLDOFF_LAST = 24'd2047;
  localparam logic [23:0] WAIT_LAST    = (WAIT_CYCLES == 0) ? 24'd0 : 24'(WAIT_CYCLES - 1);

`ifdef ADC_POLL_READY_EN
  localparam logic [4:0] POLL_FIRST = 5'd6;
  localparam logic [4:0] POLL_LAST  = 5'd10;
  localparam logic [4:0] LAST_STEP  = 5'd19;
  localparam logic [7:0] POLL_FINAL = 8'd254;  // poll_cnt value during the 255th poll
`else
  localparam logic [4:0] LAST_STEP  = 5'd15;
`endif

  // Op list. The pointer register is left at 0x01 after the config write, so
  // the poll reads return the config register and its OS bit.
  function automatic op_t op_at(input logic [4:0] step, input logic [7:0] cfg_hi);
    op_t op;
    op = '{kind: OP_STOP, wr_byte: 8'h00};
    case (step)
      5'd0:  op = '{kind: OP_START,     wr_byte: 8'h00};
      5'd1:  op = '{kind: OP_WRITE,     wr_byte: ADDR_WR};
      5'd2:  op = '{kind: OP_WRITE,     wr_byte: 8'h01};
      5'd3:  op = '{kind: OP_WRITE,     wr_byte: cfg_hi};
      5'd4:  op = '{kind: OP_WRITE,     wr_byte: CFG_LO};
      5'd5:  op = '{kind: OP_STOP,      wr_byte: 8'h00};
`ifdef ADC_POLL_READY_EN
      5'd6:  op = '{kind: OP_START,     wr_byte: 8'h00};
      5'd7:  op = '{kind: OP_WRITE,     wr_byte: ADDR_RD};
      5'd8:  op = '{kind: OP_READ_OS,   wr_byte: 8'h00};
      5'd9:  op = '{kind: OP_READ_SKIP, wr_byte: 8'h00};
      5'd10: op = '{kind: OP_STOP,      wr_byte: 8'h00};
      5'd11: op = '{kind: OP_START,     wr_byte: 8'h00};
      5'd12: op = '{kind: OP_WRITE,     wr_byte: ADDR_WR};
      5'd13: op = '{kind: OP_WRITE,     wr_byte: 8'h00};
      5'd14: op = '{kind: OP_STOP,      wr_byte: 8'h00};
      5'd15: op = '{kind: OP_START,     wr_byte: 8'h00};
      5'd16: op = '{kind: OP_WRITE,     wr_byte: ADDR_RD};
      5'd17: op = '{kind: OP_READ_HI,   wr_byte: 8'h00};
      5'd18: op = '{kind: OP_READ_LO,   wr_byte: 8'h00};
      5'd19: op = '{kind: OP_STOP,      wr_byte: 8'h00};
`else
      5'd6:  op = '{kind: OP_WAIT,      wr_byte: 8'h00};
      5'd7:  op = '{kind: OP_START,     wr_byte: 8'h00};
      5'd8:  op = '{kind: OP_WRITE,     wr_byte: ADDR_WR};
      5'd9:  op = '{kind: OP_WRITE,     wr_byte: 8'h00};
      5'd10: op = '{kind: OP_STOP,      wr_byte: 8'h00};
      5'd11: op = '{kind: OP_START,     wr_byte: 8'h00};
      5'd12: op = '{kind: OP_WRITE,     wr_byte: ADDR_RD};
      5'd13: op = '{kind: OP_READ_HI,   wr_byte: 8'h00};
      5'd14: op = '{kind: OP_READ_LO,   wr_byte: 8'h00};
      5'd15: op = '{kind: OP_STOP,      wr_byte: 8'h00};
`endif
      default: op = '{kind: OP_STOP,    wr_byte: 8'h00};
    endcase
    return op;
  endfunction

  function automatic instr_e kind_to_instr(input op_kind_e kind);
    case (kind)
      OP_START: return INSTR_START;
      OP_STOP:  return INSTR_STOP;
      OP_WRITE: return INSTR_WRITE;
      default:  return INSTR_READ;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [23:0] cnt_q, cnt_d;        // holdoff and conversion-wait counter
  logic [1:0]  channel_q, channel_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic [7:0]  data_lo_q, data_lo_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d;
`ifdef ADC_POLL_READY_EN
  logic        poll_os_q, poll_os_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
`endif

  logic [7:0]  cfg_hi;
  op_t         cur_op;

  // OS=1 starts a conversion, MUX[2]=1 selects single-ended AINx vs GND,
  // MODE=1 is single-shot.
  assign cfg_hi = {1'b1, 1'b1, channel_q, PGA, 1'b1};
  assign cur_op = op_at(step_q, cfg_hi);

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HOLDOFF;
      step_q     <= '0;
      cnt_q      <= '0;
      channel_q  <= '0;
      data_hi_q  <= '0;
      data_lo_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
`ifdef ADC_POLL_READY_EN
      poll_os_q  <= 1'b0;
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      channel_q  <= channel_d;
      data_hi_q  <= data_hi_d;
      data_lo_q  <= data_lo_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
`ifdef ADC_POLL_READY_EN
      poll_os_q  <= poll_os_d;
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  // Next-state and datapath updates.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    channel_d  = channel_q;
    data_hi_d  = data_hi_q;
    data_lo_d  = data_lo_q;
    data_d     = data_q;
`ifdef ADC_POLL_READY_EN
    poll_os_d  = poll_os_q;
    poll_cnt_d = poll_cnt_q;
`endif

    case (state_q)
      // Give an engine that kept running through our reset time to drain.
      S_HOLDOFF: begin
        if (cnt_q == HOLDOFF_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          step_d    = '0;
          channel_d = channel;
`ifdef ADC_POLL_READY_EN
          poll_os_d  = 1'b0;
          poll_cnt_d = '0;
`endif
        end
      end

      S_ISSUE: state_d = S_ARMED;

      // The engine still shows the previous op's complete here.
      S_ARMED: state_d = S_WAIT_DONE;

      S_WAIT_DONE: begin
        if (i2c.complete) begin
          state_d = S_RELEASE;
          case (cur_op.kind)
            OP_READ_HI: data_hi_d = i2c.byte_received;
            OP_READ_LO: data_lo_d = i2c.byte_received;
`ifdef ADC_POLL_READY_EN
            OP_READ_OS: poll_os_d = i2c.byte_received[7];
`endif
            default: ;
          endcase
        end
      end

      S_RELEASE: begin
        if (step_q == LAST_STEP) begin
          state_d = S_DONE;
          data_d  = {data_hi_q, data_lo_q};
`ifdef ADC_POLL_READY_EN
        end else if (step_q == POLL_LAST && !poll_os_q && poll_cnt_q != POLL_FINAL) begin
          state_d    = S_ISSUE;
          step_d     = POLL_FIRST;
          poll_cnt_d = poll_cnt_q + 8'd1;
`endif
        end else if (op_at(step_q + 5'd1, cfg_hi).kind == OP_WAIT) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ISSUE;
            step_d  = step_q + 5'd2;
          end else begin
            state_d = S_DELAY;
            step_d  = step_q + 5'd1;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_ISSUE;
          step_d  = step_q + 5'd1;
        end
      end

      S_DELAY: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
          step_d  = step_q + 5'd1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_HOLDOFF;
    endcase
  end

  // busy is registered from the next state so it rises the cycle after an
  // accepted start while still reading 0 during reset.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  // Outputs decoded from the current state. Instruction and byte hold for
  // the whole op, including the RELEASE cycle where enable is low.
  always_comb begin
    i2c.enable       = 1'b0;
    i2c.instruction  = INSTR_START;
    i2c.byte_to_send = 8'h00;
    if (state_q inside {S_ISSUE, S_ARMED, S_WAIT_DONE, S_RELEASE}) begin
      i2c.instruction  = kind_to_instr(cur_op.kind);
      i2c.byte_to_send = (cur_op.kind == OP_WRITE) ? cur_op.wr_byte : 8'h00;
      i2c.enable       = (state_q != S_RELEASE);
    end
  end

  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_ads1115_sequencer.sv
// tb_ads1115_sequencer
// Self-checking bench for ads1115_sequencer. A behavioural engine model
// asserts complete 100 cycles after enable, holds it until enable drops, and
// leaves it stale until it has seen the next enable. Expected ops and results
// are queued when a run is launched; monitors pop and compare them.
// Build with ADC_POLL_READY_EN defined to exercise the poll variant.
module tb_ads1115_sequencer;

  localparam int WAIT_CYC = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  channel = 2'd0;
  logic        busy;
  logic [15:0] data;
  logic        data_valid;

  ads1115_sequencer_if i2c();

  ads1115_sequencer #(
    .I2C_ADDR   (7'h48),
    .PGA        (3'b001),
    .DR         (3'b100),
    .WAIT_CYCLES(WAIT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .channel   (channel),
    .busy      (busy),
    .data      (data),
    .data_valid(data_valid),
    .i2c       (i2c)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- engine model ----------------
  logic       eng_complete = 1'b0;
  logic [7:0] eng_byte     = 8'h00;
  int         eng_cnt      = 0;
  logic [7:0] rd_q[$];

  assign i2c.complete      = eng_complete;
  assign i2c.byte_received = eng_byte;

  always @(posedge clk) begin
    if (i2c.enable) begin
      if (eng_cnt == 1) eng_complete <= 1'b0;  // stale flag clears one cycle late
      if (eng_cnt == 100) begin
        eng_complete <= 1'b1;
        if (i2c.instruction == 2'd2)
          eng_byte <= (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
      end
      if (eng_cnt < 1000) eng_cnt <= eng_cnt + 1;
    end else begin
      eng_cnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0] instr;
    logic [7:0] wr;
    int         gap;   // enable-low cycles before this op, -1 = don't care
  } exp_op_t;

  exp_op_t     exp_ops[$];
  logic [15:0] exp_data[$];

  task automatic push_op(input logic [1:0] i, input logic [7:0] b, input int g);
    exp_op_t e;
    e.instr = i;
    e.wr    = b;
    e.gap   = g;
    exp_ops.push_back(e);
  endtask

  // Full expected op list for one run; cfg_hi is hand-computed per channel.
  task automatic push_run(input logic [7:0] cfg_hi, input int polls, input logic [15:0] d);
    push_op(2'd0, 8'h00, -1);
    push_op(2'd3, 8'h90, 1);
    push_op(2'd3, 8'h01, 1);
    push_op(2'd3, cfg_hi, 1);
    push_op(2'd3, 8'h83, 1);
    push_op(2'd1, 8'h00, 1);
`ifdef ADC_POLL_READY_EN
    for (int p = 0; p < polls; p++) begin
      push_op(2'd0, 8'h00, 1);
      push_op(2'd3, 8'h91, 1);
      push_op(2'd2, 8'h00, 1);
      push_op(2'd2, 8'h00, 1);
      push_op(2'd1, 8'h00, 1);
    end
    push_op(2'd0, 8'h00, 1);
`else
    push_op(2'd0, 8'h00, 1 + WAIT_CYC);
`endif
    push_op(2'd3, 8'h90, 1);
    push_op(2'd3, 8'h00, 1);
    push_op(2'd1, 8'h00, 1);
    push_op(2'd0, 8'h00, 1);
    push_op(2'd3, 8'h91, 1);
    push_op(2'd2, 8'h00, 1);
    push_op(2'd2, 8'h00, 1);
    push_op(2'd1, 8'h00, 1);
    exp_data.push_back(d);
  endtask

  // ---------------- monitors ----------------
  logic       prev_en = 1'b0;
  int         en_len = 0;
  int         lo_len = 0;
  bit         have_fall = 1'b0;
  logic [1:0] cur_instr = 2'd0;
  bit         dv_prev = 1'b0;
  int         dv_count = 0;
  int         fall_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en   = 1'b0;
      en_len    = 0;
      lo_len    = 0;
      have_fall = 1'b0;
      dv_prev   = 1'b0;
    end else begin
      if (i2c.enable && !prev_en) begin
        if (exp_ops.size() == 0) begin
          check("unexpected_op", 1'b0, i2c.instruction, 0);
        end else begin
          exp_op_t e;
          e = exp_ops.pop_front();
          check("op_instr", i2c.instruction == e.instr, i2c.instruction, e.instr);
          if (e.instr == 2'd3)
            check("op_write_byte", i2c.byte_to_send == e.wr, i2c.byte_to_send, e.wr);
          if (e.gap >= 0 && have_fall)
            check("op_gap", lo_len == e.gap, lo_len, e.gap);
        end
        check("busy_during_op", busy == 1'b1, busy, 1);
        cur_instr = i2c.instruction;
        en_len = 1;
      end else if (i2c.enable) begin
        en_len++;
      end

      if (!i2c.enable && prev_en) begin
        check("enable_high_len_min101", en_len >= 101, en_len, 101);
        check("instr_held_release", i2c.instruction == cur_instr, i2c.instruction, cur_instr);
        have_fall = 1'b1;
        lo_len = 1;
        fall_count++;
      end else if (!i2c.enable) begin
        lo_len++;
      end

      if (dv_prev) begin
        check("busy_after_valid", busy == 1'b0, busy, 0);
        check("valid_one_cycle", data_valid == 1'b0, data_valid, 0);
      end
      if (data_valid) begin
        dv_count++;
        check("busy_at_valid", busy == 1'b1, busy, 1);
        if (exp_data.size() == 0)
          check("unexpected_data_valid", 1'b0, data, 0);
        else begin
          logic [15:0] d;
          d = exp_data.pop_front();
          check("data", data == d, data, d);
        end
      end
      dv_prev = data_valid;
      prev_en = i2c.enable;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   busy == 1'b0,            busy, 0);
    check({tag, "_data"},   data == 16'h0,           data, 0);
    check({tag, "_valid"},  data_valid == 1'b0,      data_valid, 0);
    check({tag, "_enable"}, i2c.enable == 1'b0,      i2c.enable, 0);
    check({tag, "_instr"},  i2c.instruction == 2'd0, i2c.instruction, 0);
    check({tag, "_byte"},   i2c.byte_to_send == 8'h0, i2c.byte_to_send, 0);
  endtask

  // Called at a negedge just after rst_n rises; start pulses inside the
  // holdoff (including its last cycle) must be ignored.
  task automatic run_holdoff(input string tag);
    for (int k = 1; k <= 2048; k++) begin
      @(negedge clk);
      start = (k == 1000 || k == 2047);
      if (k == 1000) check({tag, "_busy_mid"},  busy == 1'b1, busy, 1);
      if (k == 2047) check({tag, "_busy_last"}, busy == 1'b1, busy, 1);
      if (k == 2048) check({tag, "_busy_idle"}, busy == 1'b0, busy, 0);
    end
    @(negedge clk);
    check({tag, "_start_ignored"}, busy == 1'b0, busy, 0);
  endtask

  task automatic pulse_start(input logic [1:0] ch);
    @(negedge clk);
    start = 1'b1;
    channel = ch;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy == 1'b1, busy, 1);
  endtask

  // Returns at the negedge of the data_valid cycle.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_valid && n < 20000);
    check({tag, "_valid_timeout"}, data_valid == 1'b1, n, 20000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;

    #1;
    check_reset_outputs("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    run_holdoff("holdoff1");

    // Run 1: channel 2, result 0x1234; a start during the wait is ignored.
`ifdef ADC_POLL_READY_EN
    rd_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h12, 8'h34};
    push_run(8'hE3, 3, 16'h1234);
`else
    rd_q = '{8'h12, 8'h34};
    push_run(8'hE3, 0, 16'h1234);
`endif
    base = fall_count;
    pulse_start(2'd2);
    n = 0;
    while (fall_count < base + 6 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("config_stop_timeout", fall_count >= base + 6, fall_count - base, 6);
    repeat (5) @(negedge clk);
    start = 1'b1;
    channel = 2'd3;
    @(negedge clk);
    start = 1'b0;

    // Run 2 is queued now and started in the cycle busy falls; no read data
    // from the model means an absent slave, so the result is 0xFFFF.
    push_run(8'hF3, 1, 16'hFFFF);
    wait_valid("run1");
    @(negedge clk);
    start = 1'b1;
    channel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy_back_to_back", busy == 1'b1, busy, 1);
    wait_valid("run2");
    repeat (3) @(negedge clk);
    check("runs_1_2_valid_count", dv_count == 2, dv_count, 2);

    // Run 3: reset while a READ is in flight.
    push_run(8'hD3, 1, 16'hBEEF);
    pulse_start(2'd1);
    n = 0;
    while (!(i2c.enable && i2c.instruction == 2'd2) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("read_phase_timeout", i2c.enable && i2c.instruction == 2'd2, n, 10000);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_ops.delete();
    exp_data.delete();
    rd_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_holdoff("holdoff2");
    check("abort_no_valid", dv_count == 2, dv_count, 2);

    // Run 4: channel 1, result 0x8001 after recovery.
`ifdef ADC_POLL_READY_EN
    rd_q = '{8'h80, 8'h00, 8'h80, 8'h01};
`else
    rd_q = '{8'h80, 8'h01};
`endif
    push_run(8'hD3, 1, 16'h8001);
    pulse_start(2'd1);
    wait_valid("run4");
    repeat (10) @(negedge clk);
    check("total_valid_count", dv_count == 3, dv_count, 3);
    check("ops_drained", exp_ops.size() == 0, exp_ops.size(), 0);
    check("data_drained", exp_data.size() == 0, exp_data.size(), 0);
    check("final_idle", busy == 1'b0, busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ads1115_sequencer.md
# ads1115_sequencer

Transaction sequencer that sits directly upstream of the byte-level I2C engine and drives its instruction/enable/complete handshake. On a `start` pulse it runs a complete single-shot conversion on an ADS1115: config write, conversion wait, pointer write, then a two-byte read. It presents the 16-bit result with a one-cycle valid strobe. It owns no bus pins; SDA/SCL stay in the engine.

## Interface
- `I2C_ADDR`, default 7'h48: 7-bit ADS1115 slave address.
- `PGA`, default 3'b001: config PGA field (±4.096 V).
- `DR`, default 3'b100: config data-rate field (128 SPS).
- `WAIT_CYCLES`, default 250000: fixed conversion wait in clk cycles (24-bit counter).
- `clk`  in  1  system clock; everything is in this domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request; accepted only when `busy`=0.
- `channel`  in  2  single-ended input AIN0..3; latched on the accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `data_valid` cycle.
- `data`  out  16  last conversion result, MSB first off the bus.
- `data_valid`  out  1  one-cycle pulse when `data` updates.
- `i2c_instruction`  out  2  0=START, 1=STOP, 2=READ, 3=WRITE.
- `i2c_enable`  out  1  engine request level.
- `i2c_byte_to_send`  out  8  byte for WRITE.
- `i2c_byte_received`  in  8  engine receive register.
- `i2c_complete`  in  1  engine done flag.

## Operation
- Op list, executed in order by a step counter:
  - Config: START, WRITE {I2C_ADDR,0}, WRITE 8'h01, WRITE cfg_hi, WRITE cfg_lo, STOP.
  - Wait: WAIT.
  - Pointer: START, WRITE {I2C_ADDR,0}, WRITE 8'h00, STOP.
  - Read: START, WRITE {I2C_ADDR,1}, READ (→ data_hi), READ (→ data_lo), STOP.
- cfg_hi = {1'b1, 1'b1, channel, PGA, 1'b1}, which sets OS, single-ended MUX, and single-shot mode. cfg_lo = {DR, 5'b00011}, which disables the comparator.
- Per-op handshake, states ISSUE → ARMED → WAIT_DONE → RELEASE:
  - ISSUE: drive instruction and byte, assert `i2c_enable`.
  - ARMED: one cycle in which `i2c_complete` is ignored, because the engine still shows the previous op's stale complete until it sees enable.
  - WAIT_DONE: hold until `i2c_complete`=1. On a READ, capture `i2c_byte_received` in this same cycle.
  - RELEASE: deassert `i2c_enable` for exactly one cycle so the engine returns to idle, then advance the step.
- `i2c_instruction`/`i2c_byte_to_send` are stable from ISSUE through RELEASE.
- Top FSM: HOLDOFF → IDLE → RUN (op list) → DONE (1 cycle: `data` <= {hi,lo}, `data_valid`=1) → IDLE.
- ACK is not checked. The engine ACKs both read bytes. A missing slave yields data 16'hFFFF, not an error.
- `start` while `busy` is ignored and not queued.

## Timing
- Reset values: `busy`=0, `data`=0, `data_valid`=0, `i2c_enable`=0, `i2c_instruction`=0, `i2c_byte_to_send`=0. Internal step and wait counters are 0. The FSM starts in HOLDOFF.
- HOLDOFF is 2048 cycles with `busy`=1. This lets an engine that is not reset finish any byte it had in flight and drain to idle.
- Reset mid-transaction: all outputs return to reset values immediately, no data_valid is produced, and HOLDOFF runs again.
- Overhead per op is 3 cycles (ISSUE, ARMED, RELEASE) beyond the engine's own duration.
- WAIT lasts exactly WAIT_CYCLES cycles with `i2c_enable`=0. WAIT_CYCLES=0 skips it.
- `start` accepted in cycle N gives `busy`=1 in N+1 and ISSUE of the first START in N+1.
- `data_valid` is asserted the cycle after the final STOP's RELEASE. `busy` falls one cycle after `data_valid`. A new `start` is accepted in that same cycle.

## Configuration
- `ADC_POLL_READY_EN` defined: the WAIT op is replaced by a poll loop. The loop repeats START, WRITE {addr,1}, READ, READ, STOP with the pointer still at 0x01. It exits when bit 7 of the first byte (OS) is 1, then proceeds with the pointer write. There is a cap of 255 polls, after which the sequencer proceeds anyway. `WAIT_CYCLES` is unused.
- Undefined: fixed WAIT_CYCLES delay and no poll logic is synthesized.

## Test plan
All scenarios use a behavioural engine model that asserts complete 100 cycles after enable and holds it until enable drops.
- Reset release, then `start` with channel=2 → write bytes 8'h90, 8'h01, 8'hE3, 8'h83 in order, then STOP.
- Full run with model read bytes 8'h12, 8'h34 → `data`=16'h1234 and a one-cycle `data_valid`; `busy` falls the next cycle.
- Model leaves stale complete=1 from the previous op → no op is skipped; each enable high period is ≥101 cycles.
- `start` pulsed during WAIT → ignored; exactly one `data_valid` per accepted start.
- `rst_n` low during the read phase → `i2c_enable`=0 in the same cycle. `start` is then ignored for 2048 cycles.
- `ADC_POLL_READY_EN`: model returns OS=0 twice then 1 → three poll reads, then pointer write and final data.
